// File: rtl/pipeline_stall_sequencer_if.sv
// ============================================================================
// Module : pipeline_stall_sequencer_if
// Brief  : Decode-controller / pipeline-register bundle for the stall sequencer.
//          stallCount exists only when STALL_PERF_CNT_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface pipeline_stall_sequencer_if;
  logic       ctrlStall;
  logic       ctrlPop;
  logic       exMemRead;
  logic [2:0] exRd;
  logic [2:0] idRs1;
  logic [2:0] idRs2;
  logic       idUseRs1;
  logic       idUseRs2;
  logic       enablePC;
  logic       enableIFID;
  logic       flushIFID;
  logic       flushIDEX;
  logic       busy;
`ifdef STALL_PERF_CNT_EN
  logic [15:0] stallCount;

  modport master (
    output ctrlStall, ctrlPop, exMemRead, exRd, idRs1, idRs2, idUseRs1, idUseRs2,
    input  enablePC, enableIFID, flushIFID, flushIDEX, busy, stallCount
  );

  modport slave (
    input  ctrlStall, ctrlPop, exMemRead, exRd, idRs1, idRs2, idUseRs1, idUseRs2,
    output enablePC, enableIFID, flushIFID, flushIDEX, busy, stallCount
  );
`else
  modport master (
    output ctrlStall, ctrlPop, exMemRead, exRd, idRs1, idRs2, idUseRs1, idUseRs2,
    input  enablePC, enableIFID, flushIFID, flushIDEX, busy
  );

  modport slave (
    input  ctrlStall, ctrlPop, exMemRead, exRd, idRs1, idRs2, idUseRs1, idUseRs2,
    output enablePC, enableIFID, flushIFID, flushIDEX, busy
  );
`endif
endinterface

`default_nettype wire

// File: rtl/pipeline_stall_sequencer.sv
// ============================================================================
// Module : pipeline_stall_sequencer
// Brief  : Moore FSM turning redirect/pop requests and load-use hazards into
//          PC-hold, IF/ID-hold and bubble sequences. Optional macro
//          STALL_PERF_CNT_EN adds a saturating 16-bit stall-cycle counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipeline_stall_sequencer #(
  parameter int FLUSH_CYCLES = 1,
  parameter int RET_CYCLES   = 1,
  parameter int CNT_W        = 3
) (
  input  wire logic                  clock,
  input  wire logic                  reset,
  pipeline_stall_sequencer_if.slave  bus
);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_LDUSE   = 2'd1;
  localparam logic [1:0] S_FLUSH   = 2'd2;
  localparam logic [1:0] S_RETWAIT = 2'd3;

  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] RET_INIT   = CNT_W'(RET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic hazard;
  logic rs1_hit;
  logic rs2_hit;

  logic enable_pc;
  logic enable_ifid;
  logic flush_ifid;
  logic flush_idex;
  logic busy_int;

  // R0 is compared like any other register.
  assign rs1_hit = bus.idUseRs1 && (bus.idRs1 == bus.exRd);
  assign rs2_hit = bus.idUseRs2 && (bus.idRs2 == bus.exRd);
  assign hazard  = bus.exMemRead && (rs1_hit || rs2_hit);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_RUN: begin
        if (bus.ctrlStall && bus.ctrlPop) begin
          state_nxt = S_RETWAIT;
          cnt_nxt   = RET_INIT;
        end else if (bus.ctrlStall) begin
          state_nxt = S_FLUSH;
          cnt_nxt   = FLUSH_INIT;
        end else if (hazard) begin
          state_nxt = S_LDUSE;
        end
      end
      S_LDUSE: begin
        state_nxt = S_RUN;
      end
      S_FLUSH: begin
        if (cnt == '0) begin
          state_nxt = S_RUN;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_RETWAIT: begin
        // Return data is available: redirect through a normal flush.
        if (cnt == '0) begin
          state_nxt = S_FLUSH;
          cnt_nxt   = FLUSH_INIT;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = S_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    enable_pc   = 1'b1;
    enable_ifid = 1'b1;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    busy_int    = 1'b1;
    case (state)
      S_RUN: begin
        busy_int = 1'b0;
      end
      S_LDUSE: begin
        enable_pc   = 1'b0;
        enable_ifid = 1'b0;
        flush_idex  = 1'b1;
      end
      S_FLUSH: begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end
      S_RETWAIT: begin
        enable_pc   = 1'b0;
        enable_ifid = 1'b0;
        flush_ifid  = 1'b1;
        flush_idex  = 1'b1;
      end
      default: begin
        busy_int = 1'b1;
      end
    endcase
  end

  assign bus.enablePC   = enable_pc;
  assign bus.enableIFID = enable_ifid;
  assign bus.flushIFID  = flush_ifid;
  assign bus.flushIDEX  = flush_idex;
  assign bus.busy       = busy_int;

`ifdef STALL_PERF_CNT_EN
  logic [15:0] stall_count;
  logic        stall_cycle;

  assign stall_cycle = !enable_pc || flush_ifid;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall_cycle && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

  assign bus.stallCount = stall_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stall_sequencer.sv
// ============================================================================
// Module : tb_pipeline_stall_sequencer
// Brief  : Directed bench driving two sequencer instances (FLUSH=2/RET=1 and
//          FLUSH=1/RET=2) with shared stimulus and hand-computed expectations.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_stall_sequencer;

  // {enablePC, enableIFID, flushIFID, flushIDEX, busy}
  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_LDUSE = 5'b00011;
  localparam logic [4:0] O_FLUSH = 5'b11111;
  localparam logic [4:0] O_RETW  = 5'b00111;

  logic       clock;
  logic       reset;
  logic       ctrl_stall;
  logic       ctrl_pop;
  logic       ex_mem_read;
  logic [2:0] ex_rd;
  logic [2:0] id_rs1;
  logic [2:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;

  int checks   = 0;
  int failures = 0;

  pipeline_stall_sequencer_if bus_a ();
  pipeline_stall_sequencer_if bus_b ();

  assign bus_a.ctrlStall = ctrl_stall;
  assign bus_a.ctrlPop   = ctrl_pop;
  assign bus_a.exMemRead = ex_mem_read;
  assign bus_a.exRd      = ex_rd;
  assign bus_a.idRs1     = id_rs1;
  assign bus_a.idRs2     = id_rs2;
  assign bus_a.idUseRs1  = id_use_rs1;
  assign bus_a.idUseRs2  = id_use_rs2;

  assign bus_b.ctrlStall = ctrl_stall;
  assign bus_b.ctrlPop   = ctrl_pop;
  assign bus_b.exMemRead = ex_mem_read;
  assign bus_b.exRd      = ex_rd;
  assign bus_b.idRs1     = id_rs1;
  assign bus_b.idRs2     = id_rs2;
  assign bus_b.idUseRs1  = id_use_rs1;
  assign bus_b.idUseRs2  = id_use_rs2;

  pipeline_stall_sequencer #(.FLUSH_CYCLES(2), .RET_CYCLES(1), .CNT_W(3)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  pipeline_stall_sequencer #(.FLUSH_CYCLES(1), .RET_CYCLES(2), .CNT_W(3)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  logic [4:0] out_a;
  logic [4:0] out_b;
  assign out_a = {bus_a.enablePC, bus_a.enableIFID, bus_a.flushIFID, bus_a.flushIDEX, bus_a.busy};
  assign out_b = {bus_b.enablePC, bus_b.enableIFID, bus_b.flushIFID, bus_b.flushIDEX, bus_b.busy};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ctrl_stall  = 1'b0;
    ctrl_pop    = 1'b0;
    ex_mem_read = 1'b0;
    ex_rd       = 3'd0;
    id_rs1      = 3'd0;
    id_rs2      = 3'd0;
    id_use_rs1  = 1'b0;
    id_use_rs2  = 1'b0;
  endtask

  task automatic hazard_rs1(input logic [2:0] rd);
    ex_mem_read = 1'b1;
    ex_rd       = rd;
    id_rs1      = rd;
    id_use_rs1  = 1'b1;
  endtask

  initial begin
    idle_inputs();
    reset      = 1'b1;
    ctrl_stall = 1'b1;
    tick();
    tick();
    check("t1_reset_a", 16'(out_a), 16'(O_RUN));
    check("t1_reset_b", 16'(out_b), 16'(O_RUN));
`ifdef STALL_PERF_CNT_EN
    check("t1_cnt_a", bus_a.stallCount, 16'd0);
`endif
    reset = 1'b0;
    idle_inputs();
    tick();
    check("t1_run_idle", 16'(out_a), 16'(O_RUN));

    // T2: load-use hazard on rs1
    hazard_rs1(3'd3);
    tick();
    idle_inputs();
    check("t2_lduse_a", 16'(out_a), 16'(O_LDUSE));
    check("t2_lduse_b", 16'(out_b), 16'(O_LDUSE));
    tick();
    check("t2_back_run", 16'(out_a), 16'(O_RUN));

    // rs1 matches but is not used: no hazard
    hazard_rs1(3'd3);
    id_use_rs1 = 1'b0;
    tick();
    check("nohaz_unused", 16'(out_a), 16'(O_RUN));

    // not a load: no hazard
    hazard_rs1(3'd6);
    ex_mem_read = 1'b0;
    tick();
    check("nohaz_noload", 16'(out_a), 16'(O_RUN));

    // R0 on rs2 is still a hazard
    idle_inputs();
    ex_mem_read = 1'b1;
    ex_rd       = 3'd0;
    id_rs2      = 3'd0;
    id_use_rs2  = 1'b1;
    tick();
    idle_inputs();
    check("haz_r0_rs2", 16'(out_a), 16'(O_LDUSE));
    tick();

    // ctrlPop alone ignored
    ctrl_pop = 1'b1;
    tick();
    idle_inputs();
    check("pop_only", 16'(out_b), 16'(O_RUN));

    // T3: flush length follows FLUSH_CYCLES
    ctrl_stall = 1'b1;
    tick();
    idle_inputs();
    check("t3_a_c1", 16'(out_a), 16'(O_FLUSH));
    check("t3_b_c1", 16'(out_b), 16'(O_FLUSH));
    tick();
    check("t3_a_c2", 16'(out_a), 16'(O_FLUSH));
    check("t3_b_c2", 16'(out_b), 16'(O_RUN));
    tick();
    check("t3_a_end", 16'(out_a), 16'(O_RUN));

    // T4: return wait then flush
    ctrl_stall = 1'b1;
    ctrl_pop   = 1'b1;
    tick();
    idle_inputs();
    check("t4_b_ret1", 16'(out_b), 16'(O_RETW));
    check("t4_a_ret1", 16'(out_a), 16'(O_RETW));
    tick();
    check("t4_b_ret2", 16'(out_b), 16'(O_RETW));
    check("t4_a_fl1", 16'(out_a), 16'(O_FLUSH));
    tick();
    check("t4_b_fl", 16'(out_b), 16'(O_FLUSH));
    check("t4_a_fl2", 16'(out_a), 16'(O_FLUSH));
    tick();
    check("t4_b_run", 16'(out_b), 16'(O_RUN));
    check("t4_a_run", 16'(out_a), 16'(O_RUN));

    // T5: redirect beats hazard; hazard during flush ignored
    ctrl_stall  = 1'b1;
    ex_mem_read = 1'b1;
    ex_rd       = 3'd5;
    id_rs2      = 3'd5;
    id_use_rs2  = 1'b1;
    tick();
    ctrl_stall = 1'b0;
    check("t5_flush1", 16'(out_a), 16'(O_FLUSH));
    tick();
    check("t5_flush2", 16'(out_a), 16'(O_FLUSH));
    idle_inputs();
    tick();
    check("t5_run", 16'(out_a), 16'(O_RUN));

    // requests during LDUSE are squashed
    hazard_rs1(3'd2);
    tick();
    idle_inputs();
    ctrl_stall = 1'b1;
    tick();
    idle_inputs();
    check("lduse_ignores_stall", 16'(out_a), 16'(O_RUN));
    tick();
    check("lduse_ignores_stall2", 16'(out_a), 16'(O_RUN));

    // T6: perf count over T2 + T4
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hazard_rs1(3'd3);
    tick();
    idle_inputs();
    tick();
    ctrl_stall = 1'b1;
    ctrl_pop   = 1'b1;
    tick();
    idle_inputs();
    tick();
    tick();
    tick();
    check("t6_run_b", 16'(out_b), 16'(O_RUN));
`ifdef STALL_PERF_CNT_EN
    check("t6_cnt_a", bus_a.stallCount, 16'd4);
    check("t6_cnt_b", bus_b.stallCount, 16'd4);
`endif

    // reset mid-RETWAIT
    ctrl_stall = 1'b1;
    ctrl_pop   = 1'b1;
    tick();
    idle_inputs();
    check("rst_mid_pre", 16'(out_b), 16'(O_RETW));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_run", 16'(out_b), 16'(O_RUN));
`ifdef STALL_PERF_CNT_EN
    check("rst_mid_cnt", bus_b.stallCount, 16'd0);
`endif
    tick();
    check("rst_mid_noflush", 16'(out_b), 16'(O_RUN));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
